// File: rtl/alu_mc.sv
// Multi-cycle ALU: AND/OR/ADD/SLT in one execute cycle, unsigned shift-add MUL in WIDTH cycles.
// done pulses 2 (ALU) or WIDTH+1 (MUL) cycles after start; start is ignored while busy.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    input  logic             binv,
    input  logic             mul,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             co,
    output logic             zero,
    output logic             ovf
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALU = 2'd1, S_MUL = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]         sel_q, sel_d;
    logic               binv_q, binv_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
    logic               co_q, co_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [WIDTH-1:0]   bb, alu_res;
    logic [WIDTH:0]     sum;
    logic               add_ovf, last_mul;

    assign last_mul = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = mul ? S_MUL : S_ALU;
            S_ALU:   state_d = S_IDLE;
            S_MUL:   if (last_mul) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shared arithmetic; b_q is consumed LSB-first by shifting it right during MUL.
    always_comb begin
        bb      = binv_q ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, bb} + {{WIDTH{1'b0}}, binv_q};
        add_ovf = (a_q[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        acc_nx  = acc_q + (b_q[0] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : {2*WIDTH{1'b0}});
        case (sel_q)
            2'b00:   alu_res = a_q & bb;
            2'b01:   alu_res = a_q | bb;
            2'b10:   alu_res = sum[WIDTH-1:0];
            default: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        endcase
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        binv_d      = binv_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        co_d        = co_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    sel_d  = sel;
                    binv_d = binv;
                    busy_d = 1'b1;
                    if (mul) begin
                        cnt_d = '0;
                        acc_d = '0;
                    end
                end
            end
            S_ALU: begin
                result_d    = alu_res;
                result_hi_d = '0;
                co_d        = sel_q[1] ? sum[WIDTH] : 1'b0;
                ovf_d       = (sel_q == 2'b10) ? add_ovf : 1'b0;
                zero_d      = (alu_res == '0);
                done_d      = 1'b1;
                busy_d      = 1'b0;
            end
            S_MUL: begin
                acc_d = acc_nx;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_mul) begin
                    result_d    = acc_nx[WIDTH-1:0];
                    result_hi_d = acc_nx[2*WIDTH-1:WIDTH];
                    co_d        = (acc_nx[2*WIDTH-1:WIDTH] != '0);
                    zero_d      = (acc_nx[WIDTH-1:0] == '0);
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            binv_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            co_q        <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            binv_q      <= binv_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            co_q        <= co_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign co        = co_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=8: directed corner cases plus random ops against an arithmetic model.
module tb_alu_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [1:0]   sel = '0;
    logic         binv = 1'b0, mul = 1'b0;
    logic         busy, done, co, zero, ovf;
    logic [W-1:0] result, result_hi;

    alu_mc #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sel(sel),
        .binv(binv), .mul(mul), .busy(busy), .done(done), .result(result),
        .result_hi(result_hi), .co(co), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         co;
        logic         zero;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t q_exp[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: true signed/unsigned integer arithmetic rather than bit-level adder logic.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic [1:0] ms, input logic mbv, input logic mm);
        exp_t r;
        int   sa, sbv, t, u, bbv, p;
        r.res = '0; r.hi = '0; r.co = 1'b0; r.ovf = 1'b0; r.cyc = 0;
        if (mm) begin
            p     = int'(ma) * int'(mb);
            r.res = 8'(p % 256);
            r.hi  = 8'(p / 256);
            r.co  = (p / 256) != 0;
        end else begin
            bbv = mbv ? (255 - int'(mb)) : int'(mb);
            sa  = $signed(ma);
            sbv = $signed(mb);
            t   = mbv ? (sa - sbv) : (sa + sbv);
            u   = int'(ma) + bbv + (mbv ? 1 : 0);
            case (ms)
                2'b00: r.res = ma & 8'(bbv);
                2'b01: r.res = ma | 8'(bbv);
                2'b10: begin
                    r.res = 8'(u % 256);
                    r.co  = u > 255;
                    r.ovf = (t > 127) || (t < -128);
                end
                default: begin
                    r.res = (t < 0) ? 8'd1 : 8'd0;
                    r.co  = u > 255;
                end
            endcase
        end
        r.zero = (r.res == 0);
        return r;
    endfunction

    // Call at a negedge; waits for busy=0, drives start for one edge, queues the expectation.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] isel,
                         input logic ibinv, input logic imul);
        exp_t e;
        int   guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            chk("busy_timeout", 1, 0);
            return;
        end
        a = ia; b = ib; sel = isel; binv = ibinv; mul = imul; start = 1'b1;
        e = model(ia, ib, isel, ibinv, imul);
        e.cyc = cyc + (imul ? W + 1 : 2);
        q_exp.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_hi"}, result_hi, 0);
        chk({tag, "_co"}, co, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    // Monitor: every done pulse pops one expectation; results must then hold.
    initial begin
        exp_t e;
        logic held;
        logic [W-1:0] last_res;
        held = 1'b0;
        last_res = '0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("result", result, e.res);
                    chk("result_hi", result_hi, e.hi);
                    chk("co", co, e.co);
                    chk("zero", zero, e.zero);
                    chk("ovf", ovf, e.ovf);
                    last_res = result;
                    held = 1'b1;
                end
            end else if (rst_n && held) begin
                chk("result_hold", result, last_res);
                held = 1'b0;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int guard;
        // Reset held for 2 cycles with start asserted.
        rst_n = 1'b0; start = 1'b1; mul = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        start = 1'b0; mul = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);

        issue(8'h7F, 8'h01, 2'b10, 1'b0, 1'b0);   // ADD overflow
        issue(8'h35, 8'h35, 2'b10, 1'b1, 1'b0);   // SUB to zero
        issue(8'h80, 8'h01, 2'b11, 1'b1, 1'b0);   // SLT -128 < 1
        issue(8'h01, 8'h80, 2'b11, 1'b1, 1'b0);   // SLT swapped
        issue(8'h80, 8'h01, 2'b10, 1'b1, 1'b0);   // SUB overflow
        issue(8'hF0, 8'h3C, 2'b00, 1'b1, 1'b0);   // AND with inverted B
        issue(8'h0F, 8'h30, 2'b01, 1'b0, 1'b0);   // OR

        // MUL 0xFF*0xFF: busy through all W multiply cycles, then a start in the done cycle.
        issue(8'hFF, 8'hFF, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) begin
            chk("mul_busy", busy, 1);
            @(negedge clk);
        end
        chk("mul_done_cycle", done, 1);
        issue(8'h12, 8'h34, 2'b10, 1'b0, 1'b0);
        issue(8'h00, 8'h9C, 2'b00, 1'b0, 1'b1);   // MUL by zero

        // Abort: MUL in flight, ignored start at cycle 3, reset at cycle 5.
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        while (q_exp.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("pre_abort_idle", busy, 0);
        a = 8'h5A; b = 8'h33; mul = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mul = 1'b0; sel = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_still", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("abort");
        for (int i = 0; i < W + 4; i++) @(negedge clk);
        issue(8'hC8, 8'h64, 2'b10, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            issue(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
                  ($urandom_range(3, 0) == 0));
        end

        guard = 0;
        while (q_exp.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", q_exp.size(), 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
